// File: rtl/pattern_driver_monitor.sv
// Vector driver and response monitor for a combinational datapath.
// Drives counter/LFSR vectors, buffers responses, folds them into a MISR.
module pattern_driver_monitor #(
  parameter int IN_W = 5,
  parameter int OUT_W = 10,
  parameter int COUNT_W = 8,
  parameter logic [IN_W-1:0] LFSR_SEED = 5'h1F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] num_vectors,
  output logic [IN_W-1:0]    dut_in,
  input  logic [OUT_W-1:0]   dut_out,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [OUT_W-1:0]   resp_data,
  output logic [15:0]        signature,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IN_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;

  logic [1:0]         state;
  logic               mode_r;
  logic [COUNT_W-1:0] num_r;
  logic [COUNT_W-1:0] count;

  logic               adv;
  logic               last;
  logic [IN_W-1:0]    vec_next;
  logic [15:0]        out_ext;
  logic               fb;
  logic [15:0]        misr_next;

  always_comb begin
    adv = !resp_valid || resp_ready;
    last = (count + 1'b1) == num_r;
    vec_next = '0;
    if (mode_r)
      vec_next = {dut_in[IN_W-2:0], dut_in[IN_W-1] ^ dut_in[2]};
    else
      vec_next = dut_in + 1'b1;
    out_ext = '0;
    out_ext[OUT_W-1:0] = dut_out;
    fb = signature[15] ^ signature[14] ^ signature[12] ^ signature[3];
    misr_next = {signature[14:0], fb} ^ out_ext;
  end

  assign busy = (state == S_DRIVE) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_r     <= 1'b0;
      num_r      <= '0;
      count      <= '0;
      dut_in     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      signature  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_r    <= mode;
            num_r     <= num_vectors;
            count     <= '0;
            signature <= '0;
            dut_in    <= mode ? SEED_EFF : '0;
            state     <= (num_vectors == '0) ? S_DONE : S_DRIVE;
          end
        end
        S_DRIVE: begin
          // a capture always refills the buffer, so valid stays high
          if (adv) begin
            resp_data  <= dut_out;
            resp_valid <= 1'b1;
            signature  <= misr_next;
            count      <= count + 1'b1;
            dut_in     <= vec_next;
            if (last)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (adv) begin
            resp_valid <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
